ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter. It is the sending side of the PS/2 link, complementing the existing keyboard receive decoder.
- Sends one command byte to the keyboard, for example 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset). It follows the inhibit/request-to-send/ACK sequence and reports completion or error.
- Sits beside the keyboard decoder on the shared PS2_CLK/PS2_DATA inouts. The top level converts the *_oe outputs to open-drain drives (oe=1 drives 0, otherwise z).
- tx_busy lets the top level ignore decoder output while a transmission is in progress.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_line_filter.sv | 55 +++++
 rtl/ps2_host_tx.sv | 192 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and its line conditioning.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    XFER,
    ACK,
    WAIT_IDLE
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NOACK   = 2'b10;

  localparam int unsigned FRAME_LEN = 11;

  // {stop, odd parity, data, start}, shifted out LSB first
  function automatic logic [FRAME_LEN-1:0] build_frame(input logic [7:0] data);
    return {1'b1, ~^data, data, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioning: 2-flop synchronizers on clock and data, debounce on clock,
// and a one-cycle strobe on each accepted falling edge of the clock.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clk_in,
  input  logic i_data_in,
  output logic o_clk_filt,
  output logic o_clk_fe,
  output logic o_data_sync
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_data_sync;
  logic          r_filt;
  logic          r_fe;
  logic [CW-1:0] r_cnt;
  logic          w_clk_s;

  assign w_clk_s = r_clk_sync[1];

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_filt      <= 1'b1;
      r_fe        <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], i_clk_in};
      r_data_sync <= {r_data_sync[0], i_data_in};
      r_fe        <= 1'b0;
      // r_cnt counts consecutive samples disagreeing with the accepted level
      if (w_clk_s == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_filt <= w_clk_s;
        r_cnt  <= '0;
        r_fe   <= ~w_clk_s;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_clk_filt  = r_filt;
  assign o_clk_fe    = r_fe;
  assign o_data_sync = r_data_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, clocked-out frame, ACK check,
// with timeout supervision. Line drives are open-drain enables (1 = pull low).
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned SETUP_CYCLES   = 500,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_ready,
  output logic       o_tx_busy,
  output logic       o_tx_done,
  output logic       o_tx_err,
  output logic [1:0] o_err_code,
  input  logic       i_ps2_clk_in,
  input  logic       i_ps2_data_in,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_data_oe
);

  localparam int unsigned PH_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int unsigned PCW    = $clog2(PH_MAX + 1);
  localparam int unsigned TCW    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PCW-1:0] INH_LAST = PCW'(INHIBIT_CYCLES - 1);
  localparam logic [PCW-1:0] SET_LAST = PCW'(SETUP_CYCLES - 1);
  localparam logic [PCW-1:0] PH_SAT   = PCW'(PH_MAX);
  localparam logic [TCW-1:0] TO_MAX   = TCW'(TIMEOUT_CYCLES);
  localparam logic [3:0]     LAST_BIT = 4'(FRAME_LEN - 2);

  state_e               r_state;
  state_e               w_state_d;
  logic [PCW-1:0]       r_phase_cnt;
  logic [TCW-1:0]       r_to_cnt;
  logic [FRAME_LEN-1:0] r_shift;
  logic [3:0]           r_bits;
  logic [1:0]           r_err_code;

  logic       w_clk_filt;
  logic       w_fe;
  logic       w_data_s;
  logic       w_active;
  logic       w_timeout;
  logic       w_accept;
  logic       w_phase_clr;
  logic       w_xfer_start;
  logic       w_shift_en;
  logic       w_done;
  logic       w_err;
  logic [1:0] w_err_sel;
  logic       w_clk_oe;
  logic       w_data_oe;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clk_in   (i_ps2_clk_in),
    .i_data_in  (i_ps2_data_in),
    .o_clk_filt (w_clk_filt),
    .o_clk_fe   (w_fe),
    .o_data_sync(w_data_s)
  );

  assign w_active  = (r_state == XFER) || (r_state == ACK) || (r_state == WAIT_IDLE);
  assign w_timeout = (r_to_cnt == TO_MAX);

  always_comb begin
    w_state_d    = r_state;
    w_accept     = 1'b0;
    w_phase_clr  = 1'b0;
    w_xfer_start = 1'b0;
    w_shift_en   = 1'b0;
    w_done       = 1'b0;
    w_err        = 1'b0;
    w_err_sel    = ERR_NONE;
    w_clk_oe     = 1'b0;
    w_data_oe    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_tx_valid) begin
          w_accept  = 1'b1;
          w_state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        w_clk_oe = 1'b1;
        if (r_phase_cnt == INH_LAST) begin
          w_phase_clr = 1'b1;
          w_state_d   = REQ;
        end
      end
      REQ: begin
        w_clk_oe  = 1'b1;
        w_data_oe = 1'b1;
        if (r_phase_cnt == SET_LAST) begin
          w_xfer_start = 1'b1;
          w_state_d    = XFER;
        end
      end
      XFER: begin
        w_data_oe = ~r_shift[0];
        if (w_fe) begin
          w_shift_en = 1'b1;
          if (r_bits == LAST_BIT) w_state_d = ACK;
        end
      end
      ACK: begin
        if (w_fe) begin
          if (w_data_s) begin
            w_err     = 1'b1;
            w_err_sel = ERR_NOACK;
            w_state_d = IDLE;
          end else begin
            w_state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (w_clk_filt && w_data_s) begin
          w_done    = 1'b1;
          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
    // Timeout overrides whatever the device-clocked states decided this cycle
    if (w_active && w_timeout) begin
      w_state_d  = IDLE;
      w_done     = 1'b0;
      w_err      = 1'b1;
      w_err_sel  = ERR_TIMEOUT;
      w_clk_oe   = 1'b0;
      w_data_oe  = 1'b0;
      w_shift_en = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= IDLE;
      r_phase_cnt <= '0;
      r_to_cnt    <= '0;
      r_shift     <= '1;
      r_bits      <= '0;
      r_err_code  <= ERR_NONE;
    end else begin
      r_state <= w_state_d;

      if (w_accept || w_phase_clr) begin
        r_phase_cnt <= '0;
      end else if ((r_state == INHIBIT || r_state == REQ) && r_phase_cnt != PH_SAT) begin
        r_phase_cnt <= r_phase_cnt + 1'b1;
      end

      if (w_xfer_start || w_fe) begin
        r_to_cnt <= '0;
      end else if (w_active && r_to_cnt != TO_MAX) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end

      if (w_accept) begin
        r_shift <= build_frame(i_tx_data);
      end else if (w_shift_en) begin
        r_shift <= {1'b1, r_shift[FRAME_LEN-1:1]};
      end

      if (w_xfer_start) begin
        r_bits <= '0;
      end else if (w_shift_en && r_bits != 4'hF) begin
        r_bits <= r_bits + 1'b1;
      end

      if (w_err) r_err_code <= w_err_sel;
    end
  end

  assign o_tx_ready    = (r_state == IDLE);
  assign o_tx_busy     = (r_state != IDLE);
  assign o_tx_done     = w_done;
  assign o_tx_err      = w_err;
  assign o_err_code    = w_err ? w_err_sel : r_err_code;
  assign o_ps2_clk_oe  = w_clk_oe;
  assign o_ps2_data_oe = w_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a behavioural PS/2 device on open-drain lines.
module tb_ps2_host_tx;

  localparam int unsigned INH  = 120;
  localparam int unsigned SET  = 20;
  localparam int unsigned TO   = 3000;
  localparam int unsigned FILT = 8;
  localparam int unsigned H    = 40;  // device clock half period in system cycles

  typedef struct packed {
    logic       is_err;
    logic [1:0] code;
  } resp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_busy, tx_done, tx_err;
  logic [1:0] err_code;
  logic       clk_oe, data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk, ps2_data;

  assign ps2_clk  = dev_clk & ~clk_oe;
  assign ps2_data = dev_data & ~data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .SETUP_CYCLES  (SET),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN    (FILT)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_tx_valid   (tx_valid),
    .i_tx_data    (tx_data),
    .o_tx_ready   (tx_ready),
    .o_tx_busy    (tx_busy),
    .o_tx_done    (tx_done),
    .o_tx_err     (tx_err),
    .o_err_code   (err_code),
    .i_ps2_clk_in (ps2_clk),
    .i_ps2_data_in(ps2_data),
    .o_ps2_clk_oe (clk_oe),
    .o_ps2_data_oe(data_oe)
  );

  always #5 clk = ~clk;

  int    cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    n_checks = 0;
  int    n_fail = 0;
  resp_t exp_q[$];
  logic  exp_bits[$];
  logic [1:0] last_code = 2'b00;

  int   t_acc = 0, t_rise = 0, t_rel = 0, t_err = 0;
  int   run = 0, last_run = 0, n_acc = 0, n_fe = 0;
  logic err_clk_oe = 1'b0, err_data_oe = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // Monitor: pops the expected response on every done/err pulse, plus timing bookkeeping
  initial begin : monitor
    logic  prev_clk_oe = 1'b0;
    logic  prev_data_oe = 1'b0;
    logic  chk_next = 1'b0;
    resp_t r;
    forever begin
      @(negedge clk);
      if (chk_next) begin
        chk_next = 1'b0;
        chk("ready_after_pulse", tx_ready, 1);
        chk("err_code_hold", err_code, last_code);
      end
      if (rst && (tx_done || tx_err)) begin
        chk("done_err_exclusive", tx_done & tx_err, 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: actual done=%0d err=%0d required none", tx_done, tx_err);
        end else begin
          r = exp_q.pop_front();
          chk("resp_is_err", tx_err, r.is_err);
          if (r.is_err) chk("err_code", err_code, r.code);
          chk_next = 1'b1;
        end
        if (tx_err) begin
          t_err       = cyc;
          err_clk_oe  = clk_oe;
          err_data_oe = data_oe;
        end
      end
      if (clk_oe) begin
        run++;
      end else if (prev_clk_oe) begin
        last_run = run;
        run      = 0;
        t_rel    = cyc;
      end
      if (data_oe && !prev_data_oe && clk_oe) t_rise = cyc;
      prev_clk_oe  = clk_oe;
      prev_data_oe = data_oe;
      if (rst && tx_valid && tx_ready) n_acc++;
      if (dut.u_filter.o_clk_fe) n_fe++;
    end
  end

  task automatic push_bits(input logic [9:0] pat, input int n);
    for (int k = 0; k < n; k++) exp_bits.push_back(pat[k]);
  endtask

  task automatic send(input logic [7:0] d);
    int guard = 0;
    @(posedge clk);
    #1;
    tx_valid = 1'b1;
    tx_data  = d;
    while (!tx_ready && guard < 10000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!tx_ready) chk("send_ready", 0, 1);
    @(posedge clk);
    #1;
    t_acc    = cyc;
    tx_valid = 1'b0;
  endtask

  // Device: waits for clock release, then gives n_clk falling edges, checking each data bit
  task automatic dev_xfer(input int n_clk, input logic ack_low);
    int   guard = 0;
    logic b;
    while (clk_oe !== 1'b0 && guard < 4 * (INH + SET)) begin
      @(negedge clk);
      guard++;
    end
    if (clk_oe !== 1'b0) chk("dev_wait_release", 0, 1);
    repeat (H) @(posedge clk);
    for (int k = 1; k <= n_clk; k++) begin
      #1;
      if (k == 11) dev_data = ack_low ? 1'b0 : 1'b1;
      dev_clk = 1'b0;
      repeat (H) @(posedge clk);
      #1;
      dev_clk = 1'b1;
      repeat (H / 2) @(posedge clk);
      if (k <= 10) begin
        @(negedge clk);
        if (exp_bits.size() == 0) begin
          chk($sformatf("bit%0d_expected_present", k), 0, 1);
        end else begin
          b = exp_bits.pop_front();
          chk($sformatf("line_bit%0d", k), ps2_data, b);
        end
      end
      repeat (H / 2) @(posedge clk);
    end
    #1;
    dev_data = 1'b1;
  endtask

  task automatic wait_resp(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL resp_timeout: actual %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: actual cycle %0d required finish", cyc);
    $fatal(1, "bench watchdog expired");
  end

  initial begin : main
    int n0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_err", tx_err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_clk_oe", clk_oe, 0);
    chk("rst_data_oe", data_oe, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);

    // 0xED: data LSB first, parity 1, stop 1
    push_bits(10'h3ED, 10);
    exp_q.push_back(resp_t'{is_err: 1'b0, code: 2'b00});
    send(8'hED);
    dev_xfer(11, 1'b1);
    wait_resp(500);

    // 0xF4: parity 0; host phase timing
    push_bits(10'h2F4, 10);
    exp_q.push_back(resp_t'{is_err: 1'b0, code: 2'b00});
    send(8'hF4);
    dev_xfer(11, 1'b1);
    wait_resp(500);
    chk("clk_oe_low_cycles", last_run, INH + SET);
    chk("data_oe_rise_delay", t_rise - t_acc, INH);

    // Silent device: timeout after clock release
    last_code = 2'b01;
    exp_q.push_back(resp_t'{is_err: 1'b1, code: 2'b01});
    send(8'h55);
    wait_resp(INH + SET + TO + 200);
    chk("timeout_cycles", t_err - t_rel, TO);
    chk("timeout_clk_oe", err_clk_oe, 0);
    chk("timeout_data_oe", err_data_oe, 0);

    // 0xFF with no ACK from the device
    last_code = 2'b10;
    push_bits(10'h3FF, 10);
    exp_q.push_back(resp_t'{is_err: 1'b1, code: 2'b10});
    send(8'hFF);
    dev_xfer(11, 1'b0);
    wait_resp(500);

    // 0x12 aborted by reset after fe 4 (bit 3 = 0 keeps data pulled low)
    push_bits(10'h312, 4);
    send(8'h12);
    dev_xfer(4, 1'b1);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_clk_oe", clk_oe, 0);
    chk("abort_data_oe", data_oe, 0);
    chk("abort_ready", tx_ready, 1);
    chk("abort_busy", tx_busy, 0);
    chk("abort_err_code", err_code, 0);
    last_code = 2'b00;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);

    // 0x5A with tx_valid held while busy: only one byte goes out
    push_bits(10'h35A, 10);
    exp_q.push_back(resp_t'{is_err: 1'b0, code: 2'b00});
    n0 = n_acc;
    send(8'h5A);
    #1;
    tx_valid = 1'b1;
    tx_data  = 8'hAA;
    fork
      dev_xfer(11, 1'b1);
      begin
        repeat (60) @(posedge clk);
        #1 tx_valid = 1'b0;
      end
    join
    wait_resp(500);
    chk("single_accept", n_acc - n0, 1);
    chk("bits_consumed", exp_bits.size(), 0);

    // Short clock glitch rejected, a long low accepted
    n0 = n_fe;
    @(posedge clk);
    #1 dev_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1 dev_clk = 1'b1;
    repeat (30) @(posedge clk);
    chk("glitch_no_fe", n_fe - n0, 0);
    #1 dev_clk = 1'b0;
    repeat (20) @(posedge clk);
    #1 dev_clk = 1'b1;
    repeat (30) @(posedge clk);
    chk("long_low_fe", n_fe - n0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
